rgb_sequencer: RTL
==================

# rgb_sequencer

Programmable colour sequencer for the board RGB LED. It replaces fixed one-second colour rotation with a 4-entry step table. Each entry holds a colour mask, an 8-bit brightness duty and a dwell time in milliseconds. The block walks the table in a loop and PWM-drives the LED pins directly. It sits between the configuration/host logic (table writes, start/stop) and the top-level `rgb_led[2:0]` pins.

## Interface
Parameters:
- `TICK_CYCLES`, 100000: clock cycles per dwell tick (1 ms at 100 MHz).
- `PWM_DIV`, 4: clock cycles per PWM counter increment. PWM period is 256·PWM_DIV cycles.

Ports:
- `clk`  in  1: single clock, all logic on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `cfg_we`  in  1: table write strobe, honoured every cycle in any state.
- `cfg_addr`  in  2: table entry written.
- `cfg_color`  in  3: colour mask. Bit 2 = red, bit 1 = green, bit 0 = blue.
- `cfg_duty`  in  8: on-time in 1/256 units of the PWM period.
- `cfg_dwell`  in  16: step duration in ticks. 0 is treated as 1.
- `num_steps`  in  2: last active entry index. Sampled only when `start` is accepted.
- `start`  in  1: pulse; begins sequence at entry 0. Accepted only in IDLE.
- `stop`  in  1: pulse; returns to IDLE. Wins over `start` in the same cycle.
- `busy`  out  1: high in RUN.
- `step_idx`  out  2: entry currently playing.
- `wrap`  out  1: one-cycle pulse when the last active step ends and entry 0 reloads.
- `rgb_led`  out  3: LED drive. Bit 2 = red, bit 1 = green, bit 0 = blue.

## Operation
- Table: 4 × 27-bit registers, cleared by `rst`. Writes land at the clock edge.
- A step load in the same cycle as a write to that entry sees the old value (read-before-write).
- States: IDLE, RUN.
  - IDLE → RUN on `start && !stop`. On this transition: latch `num_steps`, load entry 0, clear all counters.
  - RUN → IDLE on `stop`.
  - `start` in RUN is ignored.
- PWM:
  - An 8-bit `pwm_cnt` advances once per PWM_DIV cycles and wraps 255 → 0.
  - Channel i is on iff `color[i] && pwm_cnt < duty`.
  - duty 0 means always off; duty 255 means on 255/256 of the period.
- Dwell:
  - A prescaler counts 0..TICK_CYCLES-1. A tick counter counts ticks.
  - The step ends on the cycle that completes tick number max(dwell, 1).
  - On that cycle, the next entry loads: `step_idx+1`, or 0 if `step_idx == num_steps`, with `wrap` asserted.
  - Prescaler, tick counter, `pwm_cnt` and the PWM divider all restart at 0 on every step load.
- Single active step (`num_steps` = 0): entry 0 reloads every max(dwell,1)·TICK_CYCLES cycles, with `wrap` each time.
- Table writes during RUN take effect the next time that entry is loaded. The step currently playing uses its latched copy.
- IDLE drives `rgb_led` = 0, `step_idx` = 0 and `wrap` = 0.

## Timing
- Reset values: `busy` 0, `step_idx` 0, `wrap` 0, `rgb_led` 3'b000, table all zero, state IDLE.
- `rst` mid-RUN gives reset values at the next edge.
- `start` sampled at edge N: `busy` = 1 and `step_idx` = 0 after edge N. `rgb_led` first reflects entry 0 after edge N+1, because `rgb_led` is registered from the compare.
- Step length is exactly max(dwell,1)·TICK_CYCLES cycles, with no gap between steps.
- `step_idx` changes and `wrap` pulses on the same edge as the step load.
- `rgb_led` follows the new step one cycle later.
- `stop` sampled at edge N: `busy` = 0 and `rgb_led` = 0 after edge N.
- All outputs are registered; there are no combinational input→output paths.

## Structure
- Shared package `rgb_pkg`:
  - LED bit indices `RGB_RED` = 2, `RGB_GREEN` = 1, `RGB_BLUE` = 0.
  - State encoding constants `SEQ_IDLE`, `SEQ_RUN`.
  - Table entry field widths (3/8/16).
- One sub-module, `rgb_tick_gen`:
  - Parameterised modulo-N prescaler with synchronous clear and a one-cycle `tick` output.
  - Instantiated twice: TICK_CYCLES for dwell, PWM_DIV for the PWM step.
- Table, FSM, PWM compare and output register live in the top module.

## Test plan
All scenarios use TICK_CYCLES = 16 and PWM_DIV = 1 unless stated.

- Reset: `rst` high 3 cycles → `rgb_led` 000, `busy` 0, `step_idx` 0, `wrap` 0. The table reads back zero via a play of entry 0: LED off for 16 cycles.
- Sequence:
  - Setup: entries 0/1/2 = (100, 255, 1), (010, 255, 2), (001, 255, 3); `num_steps` = 2; `start`.
  - Required: `step_idx` 0 for 16 cycles, 1 for 32, 2 for 48, then 0 again.
  - Required: `wrap` high exactly one cycle at cycle 96 after start.
  - Required: only the selected colour bit is ever set.
- PWM:
  - Setup: TICK_CYCLES = 512; entry 0 = (100, 64, 1); `num_steps` = 0.
  - Required: red high for step cycles 0–63 and 256–319 (offset +1 output latency), low otherwise.
  - Required: `wrap` every 512 cycles.
- Dwell 0: entry 0 dwell = 0 → step lasts exactly 16 cycles, identical to dwell = 1.
- Control edges:
  - `stop` at cycle 5 of a step → `busy` 0 and `rgb_led` 000 after the next edge.
  - `start` and `stop` together in IDLE → stays IDLE.
  - `start` during RUN → no restart, and `step_idx` continues.
- Live reconfiguration and reset:
  - Write entry 1 = (011, 128, 1) while entry 1 is not playing → the next visit to step 1 plays the new values.
  - A write to the playing entry is not seen until its next load.
  - `rst` mid-step → reset values after one edge.

Source files
------------

// File: rtl/rgb_pkg.sv
// Shared definitions for the RGB colour sequencer.
//   - LED bit indices on rgb_led / colour masks
//   - sequencer state encoding
//   - step table entry layout (colour / duty / dwell)
package rgb_pkg;

  localparam int unsigned RGB_RED   = 2;
  localparam int unsigned RGB_GREEN = 1;
  localparam int unsigned RGB_BLUE  = 0;

  localparam int unsigned COLOR_W = 3;
  localparam int unsigned DUTY_W  = 8;
  localparam int unsigned DWELL_W = 16;

  typedef enum logic {
    SEQ_IDLE = 1'b0,
    SEQ_RUN  = 1'b1
  } seq_state_t;

  // One 27-bit table entry.
  typedef struct packed {
    logic [COLOR_W-1:0] color;
    logic [DUTY_W-1:0]  duty;
    logic [DWELL_W-1:0] dwell;
  } step_entry_t;

endpackage

// File: rtl/rgb_tick_gen.sv
// Modulo-N prescaler producing a one-cycle tick.
//   clk  : clock
//   rst  : synchronous active-high reset
//   clr  : synchronous restart of the count at 0
//   en   : count enable
//   tick : high during the enabled cycle that completes N counts
module rgb_tick_gen #(
  parameter int unsigned N = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/rgb_sequencer.sv
// Programmable 4-step colour sequencer driving the board RGB LED with PWM.
//   clk, rst           : clock, synchronous active-high reset
//   cfg_we/addr/...    : step table write port (colour, duty, dwell in ticks)
//   num_steps          : last active entry, latched when start is accepted
//   start, stop        : sequence control pulses (stop has priority)
//   busy               : sequencer running
//   step_idx           : entry currently playing
//   wrap               : one-cycle pulse when the sequence returns to entry 0
//   rgb_led            : registered LED drive {red, green, blue}
module rgb_sequencer #(
  parameter int unsigned TICK_CYCLES = 100000,
  parameter int unsigned PWM_DIV     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_we,
  input  logic [1:0]  cfg_addr,
  input  logic [2:0]  cfg_color,
  input  logic [7:0]  cfg_duty,
  input  logic [15:0] cfg_dwell,
  input  logic [1:0]  num_steps,
  input  logic        start,
  input  logic        stop,
  output logic        busy,
  output logic [1:0]  step_idx,
  output logic        wrap,
  output logic [2:0]  rgb_led
);

  import rgb_pkg::*;

  seq_state_t  state, state_next;
  step_entry_t tbl [4];
  step_entry_t cur;
  logic [1:0]  last_idx;
  logic [1:0]  next_idx;
  logic [15:0] tick_cnt;
  logic [15:0] dwell_m1;
  logic [7:0]  pwm_cnt;
  logic        dwell_tick, pwm_tick;
  logic        load_first, step_end, cnt_clr, run;

  assign run      = (state == SEQ_RUN);
  assign busy     = run;
  assign cnt_clr  = load_first || step_end;
  // Dwell 0 behaves as 1 tick.
  assign dwell_m1 = (cur.dwell == '0) ? '0 : cur.dwell - 16'd1;
  assign next_idx = (step_idx == last_idx) ? 2'd0 : step_idx + 2'd1;

  rgb_tick_gen #(.N(TICK_CYCLES)) u_dwell_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .en   (run),
    .tick (dwell_tick)
  );

  rgb_tick_gen #(.N(PWM_DIV)) u_pwm_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .en   (run),
    .tick (pwm_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= SEQ_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    load_first = 1'b0;
    step_end   = 1'b0;
    case (state)
      SEQ_IDLE: begin
        if (start && !stop) begin
          state_next = SEQ_RUN;
          load_first = 1'b1;
        end
      end
      SEQ_RUN: begin
        if (stop) state_next = SEQ_IDLE;
        else      step_end   = dwell_tick && (tick_cnt == dwell_m1);
      end
      default: state_next = SEQ_IDLE;
    endcase
  end

  // Step loads read tbl before this edge's write lands (read-before-write).
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < 4; i++) tbl[i] <= '0;
      cur      <= '0;
      last_idx <= '0;
      step_idx <= '0;
      wrap     <= 1'b0;
      tick_cnt <= '0;
      pwm_cnt  <= '0;
      rgb_led  <= '0;
    end else begin
      if (cfg_we) tbl[cfg_addr] <= '{color: cfg_color, duty: cfg_duty, dwell: cfg_dwell};

      wrap    <= 1'b0;
      rgb_led <= (run && !stop) ? (cur.color & {3{pwm_cnt < cur.duty}}) : '0;

      if (load_first) begin
        last_idx <= num_steps;
        cur      <= tbl[0];
        step_idx <= '0;
        tick_cnt <= '0;
        pwm_cnt  <= '0;
      end else if (run && stop) begin
        step_idx <= '0;
      end else if (step_end) begin
        cur      <= tbl[next_idx];
        step_idx <= next_idx;
        wrap     <= (step_idx == last_idx);
        tick_cnt <= '0;
        pwm_cnt  <= '0;
      end else if (run) begin
        if (dwell_tick) tick_cnt <= tick_cnt + 16'd1;
        if (pwm_tick)   pwm_cnt  <= pwm_cnt + 8'd1;
      end
    end
  end

endmodule
